// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared enums for the key edge bank
// Purpose: pulse-mode encoding (matches the 2-bit mode port) and the
//          per-channel debounce state encoding.
package key_pkg;

    typedef enum logic [1:0] {
        MODE_PRESS   = 2'b00,
        MODE_RELEASE = 2'b01,
        MODE_BOTH    = 2'b10,
        MODE_REPEAT  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'b00,
        ST_DEB_PRESS   = 2'b01,
        ST_HELD        = 2'b10,
        ST_DEB_RELEASE = 2'b11
    } key_state_e;

endpackage

// File: rtl/key_channel.sv
// rtl/key_channel.sv - one key: synchroniser, debounce FSM, auto-repeat, pulse
// Purpose: turns one raw asynchronous key level into a debounced level and a
//          registered one-cycle event pulse selected by the pulse mode.
// Ports:
//   clk, Reset - clock, synchronous active-high reset
//   key_i      - raw asynchronous key level (1 = pressed)
//   mode_i     - pulse mode (press / release / both / repeat)
//   level_o    - debounced level, high in HELD and DEB_RELEASE
//   pulse_o    - registered event pulse, aligned with first cycle of new level
module key_channel
    import key_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8
) (
    input  logic  clk,
    input  logic  Reset,
    input  logic  key_i,
    input  mode_e mode_i,
    output logic  level_o,
    output logic  pulse_o
);

    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    key_state_e             state_q, state_d;
    logic [DW-1:0]          deb_cnt_q, deb_cnt_d;
    logic [RW-1:0]          rep_cnt_q, rep_cnt_d;
    logic                   rep_first_q, rep_first_d;
    logic                   pulse_q, pulse_d;

    logic          sync;
    logic          level_d, rise, fall, rep_fire;
    logic [RW-1:0] rep_inc, rep_thr;

    assign sync    = sync_q[SYNC_STAGES-1];
    assign level_o = (state_q == ST_HELD) || (state_q == ST_DEB_RELEASE);
    assign pulse_o = pulse_q;

    // Debounce: the counter holds how many consecutive opposite-level samples
    // have been seen; the sample that leaves a stable state counts as the first.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (sync) begin
                    if (DEB_LAST == '0) begin
                        state_d = ST_HELD;
                    end else begin
                        state_d   = ST_DEB_PRESS;
                        deb_cnt_d = DW'(1);
                    end
                end
            end
            ST_DEB_PRESS: begin
                if (!sync) begin
                    state_d   = ST_IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q >= DEB_LAST) begin
                    state_d   = ST_HELD;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            ST_HELD: begin
                if (!sync) begin
                    if (DEB_LAST == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_DEB_RELEASE;
                        deb_cnt_d = DW'(1);
                    end
                end
            end
            default: begin
                if (sync) begin
                    state_d   = ST_HELD;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q >= DEB_LAST) begin
                    state_d   = ST_IDLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
        endcase
    end

    assign level_d = (state_d == ST_HELD) || (state_d == ST_DEB_RELEASE);
    assign rise    = level_d & ~level_o;
    assign fall    = ~level_d & level_o;

    // Auto-repeat: the counter restarts on every repeat pulse, so the target
    // is REPEAT_DELAY for the first repeat and REPEAT_PERIOD afterwards.
    assign rep_inc = (rep_cnt_q == {RW{1'b1}}) ? rep_cnt_q : rep_cnt_q + RW'(1);
    assign rep_thr = rep_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);

    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_fire    = 1'b0;
        if ((mode_i != MODE_REPEAT) || !level_d || rise) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end else if (rep_inc == rep_thr) begin
            rep_fire    = 1'b1;
            rep_cnt_d   = '0;
            rep_first_d = 1'b0;
        end else begin
            rep_cnt_d = rep_inc;
        end
    end

    always_comb begin
        pulse_d = 1'b0;
        case (mode_i)
            MODE_PRESS:   pulse_d = rise;
            MODE_RELEASE: pulse_d = fall;
            MODE_BOTH:    pulse_d = rise | fall;
            default:      pulse_d = rise | rep_fire;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            sync_q      <= '0;
            state_q     <= ST_IDLE;
            deb_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
            pulse_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], key_i};
            state_q     <= state_d;
            deb_cnt_q   <= deb_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
            pulse_q     <= pulse_d;
        end
    end

endmodule

// File: rtl/key_edge_bank.sv
// rtl/key_edge_bank.sv - bank of debounced key channels with priority encoder
// Purpose: N_KEYS independent key channels plus any-pulse flag and the index
//          of the lowest-numbered pulsing channel.
// Ports:
//   clk, Reset - clock, synchronous active-high reset
//   key        - raw asynchronous key levels (1 = pressed)
//   mode       - pulse mode: 00 press, 01 release, 10 both, 11 repeat
//   level      - debounced level per channel
//   pulse      - registered one-cycle event pulse per channel
//   any_pulse  - OR of pulse
//   pulse_id   - lowest index with pulse set, 0 when no pulse
module key_edge_bank
    import key_pkg::*;
#(
    parameter int N_KEYS          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 8,
    localparam int ID_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic [N_KEYS-1:0] key,
    input  logic [1:0]        mode,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] pulse,
    output logic              any_pulse,
    output logic [ID_W-1:0]   pulse_id
);

    mode_e mode_sel;
    assign mode_sel = mode_e'(mode);

    for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
        key_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_chan (
            .clk    (clk),
            .Reset  (Reset),
            .key_i  (key[g]),
            .mode_i (mode_sel),
            .level_o(level[g]),
            .pulse_o(pulse[g])
        );
    end

    assign any_pulse = |pulse;

    // Scan from the top down so the lowest set index wins.
    always_comb begin
        pulse_id = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            if (pulse[i]) pulse_id = ID_W'(i);
        end
    end

endmodule

// File: tb/tb_key_edge_bank.sv
// tb/tb_key_edge_bank.sv - self-checking bench for key_edge_bank
module tb_key_edge_bank;

    localparam int N   = 4;
    localparam int SS  = 2;
    localparam int DEB = 4;
    localparam int RD  = 6;
    localparam int RP  = 3;

    logic         clk = 1'b0;
    logic         Reset;
    logic [N-1:0] key;
    logic [1:0]   mode;
    logic [N-1:0] level;
    logic [N-1:0] pulse;
    logic         any_pulse;
    logic [1:0]   pulse_id;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    key_edge_bank #(
        .N_KEYS         (N),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .key      (key),
        .mode     (mode),
        .level    (level),
        .pulse    (pulse),
        .any_pulse(any_pulse),
        .pulse_id (pulse_id)
    );

    // Reference model: a delay line for the synchroniser, a run length of
    // samples disagreeing with the accepted level, and an anchor cycle from
    // which auto-repeat times are measured arithmetically.
    logic [N-1:0] dq[$];
    int           run[N];
    int           anchor[N];
    int           t = 0;
    logic [N-1:0] m_level = '0;
    logic [N-1:0] m_pulse = '0;
    logic [1:0]   m_id = '0;

    task automatic tick();
        logic [N-1:0] s, nl, rise, fall, p;
        logic         rep;
        int           e;
        @(posedge clk);
        t++;
        if (Reset) begin
            dq = {};
            for (int k = 0; k < SS; k++) dq.push_back('0);
            m_level = '0;
            m_pulse = '0;
            for (int i = 0; i < N; i++) begin
                run[i]    = 0;
                anchor[i] = t;
            end
        end else begin
            s = dq.pop_front();
            dq.push_back(key);
            nl = m_level;
            for (int i = 0; i < N; i++) begin
                if (s[i] != m_level[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        nl[i]  = s[i];
                        run[i] = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            rise = nl & ~m_level;
            fall = ~nl & m_level;
            for (int i = 0; i < N; i++) begin
                rep = 1'b0;
                if (rise[i] || !nl[i] || mode != 2'b11) begin
                    anchor[i] = t;
                end else begin
                    e   = t - anchor[i];
                    rep = (e == RD) || (e > RD && ((e - RD) % RP) == 0);
                end
                case (mode)
                    2'b00:   p[i] = rise[i];
                    2'b01:   p[i] = fall[i];
                    2'b10:   p[i] = rise[i] | fall[i];
                    default: p[i] = rise[i] | rep;
                endcase
            end
            m_level = nl;
            m_pulse = p;
        end
        m_id = '0;
        for (int i = N - 1; i >= 0; i--) if (m_pulse[i]) m_id = 2'(i);
        #1;
    endtask

    task automatic settle();
        key = '0;
        repeat (14) tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        key   = '0;
        mode  = 2'b00;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) Reset = 1'b0;
            tick();
            checks++;
            if (level !== 4'b0000 || pulse !== 4'b0000 || pulse_id !== 2'd0 || any_pulse !== 1'b0) begin
                failures++;
                $display("FAIL reset c=%0d got level=%b pulse=%b id=%0d any=%b want 0000/0000/0/0",
                         c, level, pulse, pulse_id, any_pulse);
            end
        end
    endtask

    task automatic test_press();
        int n = 0;
        mode = 2'b00;
        key  = 4'b0100;
        for (int c = 1; c <= 20 && n == 0; c++) begin
            tick();
            if (level[2]) n = c;
        end
        checks++;
        if (n != SS + DEB) begin
            failures++;
            $display("FAIL press_latency got %0d edges want %0d", n, SS + DEB);
        end
        checks++;
        if (pulse !== 4'b0100 || pulse_id !== 2'd2 || any_pulse !== 1'b1) begin
            failures++;
            $display("FAIL press_pulse got pulse=%b id=%0d any=%b want 0100/2/1", pulse, pulse_id, any_pulse);
        end
        for (int c = 0; c < 19; c++) begin
            tick();
            checks++;
            if ({level, pulse, any_pulse, pulse_id} !== {m_level, m_pulse, |m_pulse, m_id} || pulse !== 4'b0000) begin
                failures++;
                $display("FAIL press_hold c=%0d got level=%b pulse=%b id=%0d want level=%b pulse=0000",
                         c, level, pulse, pulse_id, m_level);
            end
        end
        key = '0;
        for (int c = 0; c < 15; c++) begin
            tick();
            checks++;
            if (pulse !== 4'b0000) begin
                failures++;
                $display("FAIL press_release_nopulse c=%0d got pulse=%b want 0000", c, pulse);
            end
        end
        checks++;
        if (level !== 4'b0000) begin
            failures++;
            $display("FAIL press_release_level got %b want 0000", level);
        end
    endtask

    task automatic test_glitch();
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            key  = 4'b0001;
            for (int c = 0; c < 13; c++) begin
                if (c == 3) key = '0;
                tick();
                checks++;
                if (level !== 4'b0000 || pulse !== 4'b0000) begin
                    failures++;
                    $display("FAIL glitch mode=%0d c=%0d got level=%b pulse=%b want 0000/0000",
                             m, c, level, pulse);
                end
            end
        end
    endtask

    task automatic test_both_simultaneous();
        int n;
        mode = 2'b10;
        for (int ph = 0; ph < 2; ph++) begin
            key = (ph == 0) ? 4'b1010 : 4'b0000;
            n   = 0;
            for (int c = 1; c <= 20 && n == 0; c++) begin
                tick();
                if (pulse !== 4'b0000) n = c;
            end
            checks++;
            if (n != SS + DEB || pulse !== 4'b1010 || pulse_id !== 2'd1 || level !== key) begin
                failures++;
                $display("FAIL both_ph%0d got edges=%0d pulse=%b id=%0d level=%b want %0d/1010/1/%b",
                         ph, n, pulse, pulse_id, level, SS + DEB, key);
            end
            tick();
            checks++;
            if (pulse !== 4'b0000) begin
                failures++;
                $display("FAIL both_single_ph%0d got pulse=%b want 0000", ph, pulse);
            end
            repeat (10) tick();
        end
    endtask

    task automatic test_repeat();
        int  n = 0;
        logic exp;
        mode = 2'b11;
        key  = 4'b0001;
        for (int c = 1; c <= 20 && n == 0; c++) begin
            tick();
            if (level[0]) n = c;
        end
        for (int rel = 0; rel <= 20; rel++) begin
            if (rel > 0) tick();
            exp = (rel == 0) || (rel >= RD && ((rel - RD) % RP) == 0);
            checks++;
            if (pulse[0] !== exp || level[0] !== 1'b1) begin
                failures++;
                $display("FAIL repeat rel=%0d got pulse0=%b level0=%b want %b/1", rel, pulse[0], level[0], exp);
            end
        end
        mode = 2'b00;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (pulse !== 4'b0000) begin
                failures++;
                $display("FAIL repeat_stop c=%0d got pulse=%b want 0000", c, pulse);
            end
        end
        settle();
    endtask

    task automatic test_reset_mid_hold();
        int n = 0;
        mode = 2'b00;
        key  = 4'b1000;
        for (int c = 1; c <= 20 && n == 0; c++) begin
            tick();
            if (level[3]) n = c;
        end
        repeat (5) tick();
        Reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (level !== 4'b0000 || pulse !== 4'b0000) begin
                failures++;
                $display("FAIL reset_hold c=%0d got level=%b pulse=%b want 0000/0000", c, level, pulse);
            end
        end
        Reset = 1'b0;
        n = 0;
        for (int c = 1; c <= 20 && n == 0; c++) begin
            tick();
            if (pulse[3]) n = c;
        end
        checks++;
        if (n != SS + DEB || level !== 4'b1000 || pulse_id !== 2'd3) begin
            failures++;
            $display("FAIL reset_repress got edges=%0d level=%b id=%0d want %0d/1000/3",
                     n, level, pulse_id, SS + DEB);
        end
        settle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) key[i] = ~key[i];
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            Reset = ($urandom_range(0, 299) == 0);
            tick();
            checks++;
            if ({level, pulse, any_pulse, pulse_id} !== {m_level, m_pulse, |m_pulse, m_id}) begin
                failures++;
                $display("FAIL random t=%0d got level=%b pulse=%b any=%b id=%0d want level=%b pulse=%b any=%b id=%0d",
                         t, level, pulse, any_pulse, pulse_id, m_level, m_pulse, |m_pulse, m_id);
            end
        end
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        key   = '0;
        mode  = 2'b00;
        test_reset();
        test_press();
        test_glitch();
        test_both_simultaneous();
        test_repeat();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/key_edge_bank.md
KEY_EDGE_BANK -- requirements
Module: key_edge_bank

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, number of independent key channels (1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser flops per channel (>=2).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable synchronised cycles required to accept a level change (>=1).
REQ-004 SHALL have parameter REPEAT_DELAY, default 16, cycles from press pulse to first auto-repeat pulse (>=1).
REQ-005 SHALL have parameter REPEAT_PERIOD, default 8, cycles between later auto-repeat pulses (>=1).
REQ-006 SHALL have port clk  input  1  clock.
REQ-007 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port key  input  N_KEYS  raw asynchronous key levels, 1 = pressed.
REQ-009 SHALL have port mode  input  2  pulse mode: 00 PRESS, 01 RELEASE, 10 BOTH, 11 REPEAT.
REQ-010 SHALL have port level  output  N_KEYS  debounced key level per channel.
REQ-011 SHALL have port pulse  output  N_KEYS  one-cycle event pulse per channel.
REQ-012 SHALL have port any_pulse  output  1  OR of pulse.
REQ-013 SHALL have port pulse_id  output  $clog2(N_KEYS) (min 1)  index of lowest-numbered channel with pulse set; 0 when any_pulse=0.

Function
REQ-014 Each channel SHALL pass key[i] through SYNC_STAGES flops before any other logic.
REQ-015 Each channel SHALL run FSM IDLE, DEB_PRESS, HELD, DEB_RELEASE.
REQ-016 IDLE->DEB_PRESS when sync=1; DEB_PRESS->HELD after DEBOUNCE_CYCLES consecutive sync=1 cycles; DEB_PRESS->IDLE on any sync=0.
REQ-017 HELD->DEB_RELEASE when sync=0; DEB_RELEASE->IDLE after DEBOUNCE_CYCLES consecutive sync=0 cycles; DEB_RELEASE->HELD on any sync=1.
REQ-018 level[i] SHALL be 1 exactly while state is HELD or DEB_RELEASE.
REQ-019 Latency: a clean key edge SHALL change level SYNC_STAGES+DEBOUNCE_CYCLES clock edges after the first edge sampling the new value (6 at defaults).
REQ-020 pulse[i] SHALL be registered, high for exactly one cycle, coincident with the first cycle of the new level.
REQ-021 PRESS: pulse on level 0->1 only; RELEASE: on 1->0 only; BOTH: on either; REPEAT: on 0->1 plus auto-repeat.
REQ-022 REPEAT: while in HELD/DEB_RELEASE, pulse REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles until level falls.
REQ-023 Repeat counter SHALL clear on press pulse, on level fall and whenever mode != REPEAT; it SHALL saturate, never wrap.
REQ-024 A glitch shorter than DEBOUNCE_CYCLES synchronised cycles SHALL produce no level change and no pulse.
REQ-025 A mode change SHALL take effect on the next clock edge; no pulse SHALL be generated by the mode change itself.
REQ-026 Simultaneous events on several channels SHALL set all corresponding pulse bits in the same cycle; pulse_id = lowest index.
REQ-027 any_pulse and pulse_id SHALL be combinational from the registered pulse vector (no added latency).

Reset
REQ-028 Reset SHALL clear synchronisers to 0, FSMs to IDLE, counters to 0, level and pulse to 0.
REQ-029 Reset asserted mid-debounce or while held SHALL discard the event; a key still held after release of Reset SHALL re-debounce and then produce a press pulse.

Structure
REQ-030 Package key_pkg SHALL hold the mode enum (MODE_PRESS, MODE_RELEASE, MODE_BOTH, MODE_REPEAT) and the channel state enum.
REQ-031 Per-channel logic (sync, debounce FSM, repeat counter, pulse register) SHALL be sub-module key_channel, instantiated N_KEYS times by generate; the priority encoder stays in key_edge_bank.

Verification (defaults unless stated; REPEAT_DELAY=6, REPEAT_PERIOD=3 for repeat test)
REQ-032 Reset 4 cycles, key=0000 -> level=0000, pulse=0000, pulse_id=0 throughout.
REQ-033 PRESS mode, key[2] 0->1 held 20 cycles -> level[2]=1 after 6 edges, pulse=0100 for one cycle, pulse_id=2; release -> no pulse.
REQ-034 key[0] high 3 cycles then low, any mode -> level and pulse stay 0.
REQ-035 BOTH mode, key[1] and key[3] pressed same cycle -> pulse=1010 one cycle, pulse_id=1; release -> pulse=1010 again.
REQ-036 REPEAT mode, key[0] held 20 cycles after level rise -> pulses at relative cycles 0, 6, 9, 12, 15, 18; switch mode to PRESS mid-hold -> repeats stop next cycle.
REQ-037 key[3] held, Reset pulsed mid-hold -> level=0 during Reset, then press pulse 6 edges after Reset deasserts.
